gate_bist_checker: RTL

//   Synthesizable on-chip counterpart of our gate stimulus benches. It walks an

---
 rtl/gate_bist_checker_if.sv | 45 ++++
 rtl/gate_bist_checker.sv | 135 +++++++++++++
 2 files changed

// File: rtl/gate_bist_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : gate_bist_checker_if
// Description : Gate-side vector bus and result/status signals of the gate
//               BIST checker, with checker (master) and host (slave) views.
// Revision    : 1.0 - initial release
// ============================================================================
interface gate_bist_checker_if #(
    parameter int N_IN = 5
);
    logic              start;
    logic [N_IN-1:0]   dut_in;
    logic              dut_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     err_count;
    logic [N_IN-1:0]   first_fail_vec;
    logic              first_fail_valid;

    modport master (
        input  start,
        input  dut_out,
        output dut_in,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_fail_vec,
        output first_fail_valid
    );

    modport slave (
        output start,
        output dut_out,
        input  dut_in,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_fail_vec,
        input  first_fail_valid
    );
endinterface
`default_nettype wire

// File: rtl/gate_bist_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_bist_checker
// Description : Exhaustive-sweep BIST for a combinational gate; counts
//               mismatches against a golden truth table, latches first failure.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_bist_checker #(
    parameter int                      N_IN          = 5,
    parameter int                      SETTLE_CYCLES = 1,
    parameter logic [(2**N_IN)-1:0]    EXP_TT        = '0
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    gate_bist_checker_if.master bus
);
    localparam int                ERR_W       = N_IN + 1;
    localparam int                SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]     SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [N_IN-1:0]   VEC_LAST    = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // With no settle window each vector goes straight to its sample cycle.
    localparam state_t ST_FIRST = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [N_IN-1:0]   ffvec_q, ffvec_d;
    logic              ffval_q, ffval_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic              w_mismatch;

    assign w_mismatch = (bus.dut_out != EXP_TT[vec_q]);

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        ffvec_d  = ffvec_q;
        ffval_d  = ffval_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    vec_d    = '0;
                    settle_d = '0;
                    err_d    = '0;
                    ffvec_d  = '0;
                    ffval_d  = 1'b0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    state_d  = ST_FIRST;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = ST_SAMPLE;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            ST_SAMPLE: begin
                if (w_mismatch) begin
                    err_d = err_q + ERR_W'(1);
                    if (!ffval_q) begin
                        ffvec_d = vec_q;
                        ffval_d = 1'b1;
                    end
                end
                // Termination compares against all-ones; the counter never wraps.
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    vec_d   = '0;
                    pass_d  = (err_q == '0) && !w_mismatch;
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    state_d = ST_FIRST;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            ffvec_q  <= '0;
            ffval_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            ffvec_q  <= ffvec_d;
            ffval_q  <= ffval_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign bus.dut_in           = vec_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_vec   = ffvec_q;
    assign bus.first_fail_valid = ffval_q;
endmodule
`default_nettype wire
